vec_alu_seq: RTL and testbench

- Multi-cycle vector execution stage that sits directly downstream of the 64-entry vector register file.
- Accepts one vector op per handshake and drives the register file's two read ports (registered-address, 1-cycle read latency).
- Captures both 1024-bit operands and processes 64 x 16-bit elements LANES at a time.
- Writes the full 1024-bit result back through the register file's single write port.

---
 rtl/vec_alu_seq.sv | 164 ++++++++++++++++
 tb/tb_vec_alu_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_seq.sv
// Multi-cycle vector ALU stage fed by a 64-entry x 1024-bit vector register file.
// One op is accepted per handshake in IDLE. The stage drives both read ports,
// captures the two operands, and processes the 64 x 16-bit elements LANES at a
// time. The full result goes back through the single write port.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready op handshake; ready only while idle
//   req_op/vd/vs0/vs1   opcode, destination and source register numbers
//   raddr0/raddr1       register file read addresses (file registers them)
//   rdata0/rdata1       register file read data, valid one cycle after sampling
//   wen/waddr/wdata     register file write port, registered
//   busy                high whenever not idle
//   done                one-cycle pulse in the cycle after the write
module vec_alu_seq #(
  parameter int unsigned LANES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [5:0]    req_vd,
  input  logic [5:0]    req_vs0,
  input  logic [5:0]    req_vs1,
  output logic [5:0]    raddr0,
  output logic [5:0]    raddr1,
  input  logic [1023:0] rdata0,
  input  logic [1023:0] rdata1,
  output logic          wen,
  output logic [5:0]    waddr,
  output logic [1023:0] wdata,
  output logic          busy,
  output logic          done
);

  localparam int unsigned BEATS = 64 / LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SW    = 16 * LANES;

  typedef enum logic [2:0] {StIdle, StRd, StCap, StExec, StWr} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q;
  logic [5:0]      vd_q;
  logic [1023:0]   opa_q, opb_q, res_q, res_d;
  logic [BW-1:0]   beat_q;
  logic            last_beat;
  logic [SW-1:0]   a_beat, b_beat, r_beat;

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a,
                                      input logic [15:0] b);
    logic [31:0] prod;
    logic [15:0] r;
    prod = 32'(a) * 32'(b);
    r    = '0;
    unique case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = prod[15:0];
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ($signed(a) < $signed(b)) ? a : b;
      3'd7: r = ($signed(a) > $signed(b)) ? a : b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  // Select the current beat's slice of both operands so only LANES ALUs exist.
  always_comb begin
    a_beat = '0;
    b_beat = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BW'(b)) begin
        a_beat = opa_q[SW*b +: SW];
        b_beat = opb_q[SW*b +: SW];
      end
    end
  end

  always_comb begin
    r_beat = '0;
    for (int l = 0; l < LANES; l++) begin
      r_beat[16*l +: 16] = alu(op_q, a_beat[16*l +: 16], b_beat[16*l +: 16]);
    end
  end

  // Merge the beat's results into the result vector.
  always_comb begin
    res_d = res_q;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BW'(b)) begin
        res_d[SW*b +: SW] = r_beat;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StRd;
      StRd:    state_d = StCap;
      StCap:   state_d = StExec;
      StExec:  if (last_beat) state_d = StWr;
      StWr:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      vd_q    <= '0;
      raddr0  <= '0;
      raddr1  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      beat_q  <= '0;
      wen     <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == StWr);
      wen     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q   <= req_op;
            vd_q   <= req_vd;
            raddr0 <= req_vs0;
            raddr1 <= req_vs1;
          end
        end
        StCap: begin
          opa_q  <= rdata0;
          opb_q  <= rdata1;
          beat_q <= '0;
        end
        StExec: begin
          res_q  <= res_d;
          beat_q <= beat_q + 1'b1;
          // The write data must include the final beat, so take it from res_d.
          if (last_beat) begin
            wen   <= 1'b1;
            waddr <= vd_q;
            wdata <= res_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_alu_seq.sv
// Bench for vec_alu_seq: a default-width instance plus a LANES=1 instance, both
// reading a behavioural register file; results compared to an element-wise model.
module tb_vec_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req_valid, req_ready, wen, busy, done;
  logic [2:0]    req_op;
  logic [5:0]    req_vd, req_vs0, req_vs1, raddr0, raddr1, waddr;
  logic [1023:0] rdata0, rdata1, wdata;

  logic          b_req_valid, b_req_ready, b_wen, b_busy, b_done;
  logic [2:0]    b_req_op;
  logic [5:0]    b_req_vd, b_req_vs0, b_req_vs1, b_raddr0, b_raddr1, b_waddr;
  logic [1023:0] b_rdata0, b_rdata1, b_wdata;

  vec_alu_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_vd(req_vd), .req_vs0(req_vs0), .req_vs1(req_vs1),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
    .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
  );

  vec_alu_seq #(.LANES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op(b_req_op), .req_vd(b_req_vd), .req_vs0(b_req_vs0), .req_vs1(b_req_vs1),
    .raddr0(b_raddr0), .raddr1(b_raddr1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata), .busy(b_busy), .done(b_done)
  );

  // Register file model: registered read address, single write port (dut only).
  logic [1023:0] regs [64];
  logic          tb_we = 1'b0;
  logic [5:0]    tb_wa = '0;
  logic [1023:0] tb_wd = '0;

  always @(posedge clk) begin
    rdata0   <= regs[raddr0];
    rdata1   <= regs[raddr1];
    b_rdata0 <= regs[b_raddr0];
    b_rdata1 <= regs[b_raddr1];
    if (wen) regs[waddr] <= wdata;
    else if (tb_we) regs[tb_wa] <= tb_wd;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkvec(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int idx;
    idx = 0;
    for (int i = 63; i >= 0; i--) if (obs[16*i +: 16] !== exp[16*i +: 16]) idx = i;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: element %0d observed %0h expected %0h", tag, idx,
             obs[16*idx +: 16], exp[16*idx +: 16]);
    end
  endtask

  // Reference: independent 16-bit element arithmetic.
  function automatic logic [1023:0] model(input logic [2:0] op, input logic [1023:0] a,
                                          input logic [1023:0] b);
    logic [1023:0] r;
    logic [15:0]   x, y;
    int            sx, sy;
    for (int i = 0; i < 64; i++) begin
      x  = a[16*i +: 16];
      y  = b[16*i +: 16];
      sx = int'($signed(x));
      sy = int'($signed(y));
      case (op)
        3'd0: r[16*i +: 16] = 16'((int'(x) + int'(y)) % 65536);
        3'd1: r[16*i +: 16] = 16'((int'(x) - int'(y) + 65536) % 65536);
        3'd2: r[16*i +: 16] = 16'((longint'(x) * longint'(y)) % 65536);
        3'd3: r[16*i +: 16] = x & y;
        3'd4: r[16*i +: 16] = x | y;
        3'd5: r[16*i +: 16] = x ^ y;
        3'd6: r[16*i +: 16] = (sx < sy) ? x : y;
        default: r[16*i +: 16] = (sx > sy) ? x : y;
      endcase
    end
    return r;
  endfunction

  task automatic load(input logic [5:0] idx, input logic [1023:0] v);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = idx; tb_wd = v;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  function automatic logic [1023:0] rand_vec();
    logic [1023:0] v;
    for (int j = 0; j < 32; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  // Issue one op on the default instance and check latency, write and done.
  // With hold=1, req_valid stays high so the next call chains back-to-back.
  task automatic issue(input logic [2:0] op, input logic [5:0] vd, input logic [5:0] vs0,
                       input logic [5:0] vs1, input bit hold, output logic [1023:0] got);
    logic [1023:0] exp;
    int  k;
    bit  bad_busy;
    exp = model(op, regs[vs0], regs[vs1]);
    chk("ready_before_accept", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_vd = vd; req_vs0 = vs0; req_vs1 = vs1;
    @(posedge clk); #1;
    if (!hold) begin
      req_valid = 1'b0;
      req_op = 3'($urandom); req_vd = 6'($urandom);
      req_vs0 = 6'($urandom); req_vs1 = 6'($urandom);
    end
    k = 0;
    bad_busy = 1'b0;
    @(negedge clk);
    while (!wen && k < 200) begin
      if (busy !== 1'b1 || req_ready !== 1'b0 || done !== 1'b0) bad_busy = 1'b1;
      k++;
      @(negedge clk);
    end
    chk("wen_latency", k, 6);
    chk("busy_during_op", bad_busy, 0);
    chk("waddr", waddr, vd);
    chkvec("wdata", wdata, exp);
    chk("ready_in_wr", req_ready, 0);
    got = wdata;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("wen_after_wr", wen, 0);
    chk("idle_after_wr", busy, 0);
    if (!hold) begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
  endtask

  logic [1023:0] va, vb, got;
  int            k;
  bit            saw;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_vd = '0; req_vs0 = '0; req_vs1 = '0;
    b_req_valid = 1'b0; b_req_op = '0; b_req_vd = '0; b_req_vs0 = '0; b_req_vs1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wen", wen, 0);
    chk("rst_raddr0", raddr0, 0);
    chk("rst_raddr1", raddr1, 0);
    chk("rst_waddr", waddr, 0);
    chkvec("rst_wdata", wdata, '0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) load(6'(i), rand_vec());

    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (wen || b_wen) saw = 1'b1;
    end
    chk("idle_no_wen", saw, 0);

    // ADD wrap
    load(10, {64{16'hFFFF}});
    load(11, {64{16'h0002}});
    issue(3'd0, 6'd5, 6'd10, 6'd11, 1'b0, got);
    chkvec("add_wrap_const", got, {64{16'h0001}});

    // Element ordering with SUB
    for (int i = 0; i < 64; i++) begin
      va[16*i +: 16] = 16'(i);
      vb[16*i +: 16] = 16'(3 * i);
    end
    load(12, va);
    load(13, vb);
    issue(3'd1, 6'd20, 6'd12, 6'd13, 1'b0, got);
    chk("sub_elem63", got[63*16 +: 16], 16'hFF82);

    // Same on the LANES=1 instance: 66-cycle write latency
    @(negedge clk);
    b_req_valid = 1'b1; b_req_op = 3'd1; b_req_vd = 6'd21; b_req_vs0 = 6'd12;
    b_req_vs1 = 6'd13;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!b_wen && k < 300) begin
      k++;
      @(negedge clk);
    end
    chk("b_wen_latency", k, 66);
    chk("b_waddr", b_waddr, 21);
    chkvec("b_wdata", b_wdata, model(3'd1, va, vb));
    @(negedge clk);
    chk("b_done", b_done, 1);

    // Signed MIN/MAX, MUL truncation
    load(14, {64{16'h8000}});
    load(15, {64{16'h7FFF}});
    load(16, {64{16'h0100}});
    issue(3'd6, 6'd30, 6'd14, 6'd15, 1'b0, got);
    chkvec("min_signed", got, {64{16'h8000}});
    issue(3'd7, 6'd31, 6'd14, 6'd15, 1'b0, got);
    chkvec("max_signed", got, {64{16'h7FFF}});
    issue(3'd2, 6'd32, 6'd16, 6'd16, 1'b0, got);
    chkvec("mul_trunc", got, '0);

    // Back-to-back, in place
    issue(3'd5, 6'd2, 6'd2, 6'd2, 1'b1, got);
    chkvec("xor_inplace_1", got, '0);
    issue(3'd5, 6'd2, 6'd2, 6'd2, 1'b0, got);
    chkvec("xor_inplace_2", got, '0);
    va = regs[3];
    issue(3'd0, 6'd3, 6'd3, 6'd3, 1'b1, got);
    issue(3'd0, 6'd3, 6'd3, 6'd3, 1'b0, got);
    chkvec("add_inplace_reads_new", got, model(3'd0, model(3'd0, va, va), model(3'd0, va, va)));

    // Reset in the middle of EXEC (beat 2)
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_vd = 6'd40; req_vs0 = 6'd7; req_vs1 = 6'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", req_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_wen", wen, 0);
    chk("abort_raddr0", raddr0, 0);
    chk("abort_raddr1", raddr1, 0);
    chk("abort_waddr", waddr, 0);
    chkvec("abort_wdata", wdata, '0);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (wen) saw = 1'b1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (wen) saw = 1'b1;
    end
    chk("abort_no_wen", saw, 0);
    issue(3'd4, 6'd40, 6'd7, 6'd9, 1'b0, got);

    // Random ops against the model
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 1) load(6'($urandom), rand_vec());
      issue(3'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), 1'b0, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
